// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode and buffer-state
// encodings plus the width-generic extension function.
package imm_ext_pkg;

  // Widest extended immediate the extension function supports.
  localparam int unsigned MaxW = 64;

  typedef enum logic [1:0] {
    ModeSign   = 2'b00,
    ModeZero   = 2'b01,
    ModeUpper  = 2'b10,
    ModeBranch = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    BufEmpty = 2'b00,
    BufOne   = 2'b01,
    BufFull  = 2'b10
  } buf_state_e;

  // in_w/out_w are elaboration constants at every call site, so this reduces to wiring.
  // The caller truncates the result to out_w bits.
  function automatic logic [MaxW-1:0] imm_extend(input logic [MaxW-1:0] imm,
                                                 input imm_mode_e       mode,
                                                 input int unsigned     in_w,
                                                 input int unsigned     out_w);
    logic [MaxW-1:0] mask;
    logic [MaxW-1:0] zext;
    logic [MaxW-1:0] sext;
    logic [MaxW-1:0] res;
    logic            sign;
    mask = (MaxW'(1) << in_w) - MaxW'(1);
    zext = imm & mask;
    sign = |(zext & (MaxW'(1) << (in_w - 1)));
    sext = sign ? (zext | ~mask) : zext;
    res  = zext;
    case (mode)
      ModeSign:   res = sext;
      ModeZero:   res = zext;
      ModeUpper:  res = zext << (out_w - in_w);
      ModeBranch: res = sext << 2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_buf2.sv
// Two-entry in-order buffer with valid/ready on both sides. Entry 0 always holds the
// oldest item and drives the outputs directly from flops.
module imm_buf2
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  buf_state_e        state_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic [TAG_W-1:0]  tag0_q, tag1_q;
  logic              push, pop;

  // Handshakes are masked during reset so nothing is seen to transfer in a reset cycle.
  assign in_ready  = rst_n & (state_q != BufFull);
  assign out_valid = rst_n & (state_q != BufEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = data0_q;
  assign out_tag  = tag0_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BufEmpty;
      data0_q <= '0;
      data1_q <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      unique case (state_q)
        BufEmpty: begin
          if (push) begin
            data0_q <= in_data;
            tag0_q  <= in_tag;
            state_q <= BufOne;
          end
        end
        BufOne: begin
          if (push && pop) begin
            data0_q <= in_data;
            tag0_q  <= in_tag;
          end else if (push) begin
            data1_q <= in_data;
            tag1_q  <= in_tag;
            state_q <= BufFull;
          end else if (pop) begin
            state_q <= BufEmpty;
          end
        end
        BufFull: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            data0_q <= data1_q;
            tag0_q  <= tag1_q;
            state_q <= BufOne;
          end
        end
        default: state_q <= BufEmpty;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extension stage: extends the raw field at acceptance and queues the
// extended value with its tag in a two-entry buffer. Requires OUT_W >= IN_W+2, OUT_W <= 64.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] ext_imm;

  // Only the extended value is stored; the raw field is discarded at acceptance.
  assign ext_imm = OUT_W'(imm_extend(MaxW'(in_imm), imm_mode_e'(in_mode), IN_W, OUT_W));

  imm_buf2 #(
    .DATA_W(OUT_W),
    .TAG_W (TAG_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (ext_imm),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_imm),
    .out_tag  (out_tag)
  );

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed scenarios plus a random phase, with a
// queue-based scoreboard fed at input acceptance and drained at output transfer.
module tb_imm_ext_pipe;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] prev_imm;
  logic [TAG_W-1:0] prev_tag;

  imm_ext_pipe #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {{16{imm[15]}}, imm};
      2'b01:   return {16'h0000, imm};
      2'b10:   return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  // Scoreboard: inputs are stable from just after posedge to the next posedge,
  // so sampling at negedge sees exactly what the next edge will transfer.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_imm", 64'(out_imm), 64'(prev_imm));
        check("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_imm", 64'(out_imm), 64'(e.imm));
          check("sb_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{imm: model_ext(in_imm, in_mode), tag: in_tag});
      stall_prev = out_valid && !out_ready;
      prev_imm   = out_imm;
      prev_tag   = out_tag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    step();

    // Sign extension with latency 1.
    out_ready = 1'b1;
    set_in(1'b1, 16'h8000, 2'b00, 5'd1);
    step();
    check("sign_valid", 64'(out_valid), 64'd1);
    check("sign_imm", 64'(out_imm), 64'hFFFF8000);
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();

    // Zero then upper on consecutive cycles.
    set_in(1'b1, 16'h8000, 2'b01, 5'd2);
    step();
    check("zero_imm", 64'(out_imm), 64'h00008000);
    set_in(1'b1, 16'h1234, 2'b10, 5'd3);
    step();
    check("upper_valid", 64'(out_valid), 64'd1);
    check("upper_imm", 64'(out_imm), 64'h12340000);

    // Branch offsets.
    set_in(1'b1, 16'hFFFF, 2'b11, 5'd7);
    step();
    check("br_neg_imm", 64'(out_imm), 64'hFFFFFFFC);
    check("br_neg_tag", 64'(out_tag), 64'd7);
    set_in(1'b1, 16'h0001, 2'b11, 5'd8);
    step();
    check("br_pos_imm", 64'(out_imm), 64'h00000004);
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();
    check("idle_empty", 64'(out_valid), 64'd0);

    // Backpressure: three back-to-back pushes, third held while full.
    out_ready = 1'b0;
    set_in(1'b1, 16'h0011, 2'b01, 5'd11);
    step();
    check("bp_ready_one", 64'(in_ready), 64'd1);
    set_in(1'b1, 16'h0022, 2'b01, 5'd12);
    step();
    check("bp_ready_full", 64'(in_ready), 64'd0);
    set_in(1'b1, 16'h0033, 2'b01, 5'd13);
    step();
    check("bp_held_ready", 64'(in_ready), 64'd0);
    check("bp_head_imm", 64'(out_imm), 64'h00000011);
    // Full with pop and pending push: only the pop happens.
    out_ready = 1'b1;
    step();
    check("fullpop_ready", 64'(in_ready), 64'd1);
    check("fullpop_head", 64'(out_imm), 64'h00000022);
    step();
    check("pend_accepted", 64'(out_imm), 64'h00000033);
    check("pend_tag", 64'(out_tag), 64'd13);
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Sustained throughput.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 16'(16'h0100 + i), 2'(i), 5'(i));
      step();
      check("tput_ready", 64'(in_ready), 64'd1);
      check("tput_valid", 64'(out_valid), 64'd1);
    end
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();

    // Reset while full discards both entries.
    out_ready = 1'b0;
    set_in(1'b1, 16'hAAAA, 2'b00, 5'd20);
    step();
    set_in(1'b1, 16'hBBBB, 2'b00, 5'd21);
    step();
    check("pre_rst_full", 64'(in_ready), 64'd0);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 16'hCCCC, 2'b00, 5'd22);
    #1;
    check("in_rst_ready", 64'(in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    #1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_imm", 64'(out_imm), 64'd0);
    check("post_rst_tag", 64'(out_tag), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_stale", 64'(out_valid), 64'd0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom), 5'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16: raw immediate width.
REQ-002 SHALL have parameter OUT_W, default 32: extended width; legal only when OUT_W >= IN_W+2.
REQ-003 SHALL have parameter TAG_W, default 5: sideband tag width (destination register index).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream item present.
REQ-007 SHALL have port in_ready  output  1  block can accept an item this cycle.
REQ-008 SHALL have port in_imm  input  IN_W  raw immediate field.
REQ-009 SHALL have port in_mode  input  2  extension mode.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband tag, carried unchanged.
REQ-011 SHALL have port out_valid  output  1  extended item present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the item.
REQ-013 SHALL have port out_imm  output  OUT_W  extended immediate.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the item on out_imm.

Function
REQ-015 SHALL transfer on input when in_valid & in_ready and on output when out_valid & out_ready.
REQ-016 SHALL apply mode 00 SIGN: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
REQ-017 SHALL apply mode 01 ZERO: fill bits OUT_W-1..IN_W with 0.
REQ-018 SHALL apply mode 10 UPPER: place in_imm in bits OUT_W-1..OUT_W-IN_W, lower bits 0.
REQ-019 SHALL apply mode 11 BRANCH: sign-extend, shift left by 2, truncate to OUT_W.
REQ-020 SHALL compute extension at input acceptance and store the result, not the raw field.
REQ-021 SHALL buffer items in a 2-entry in-order store with states EMPTY, ONE, FULL.
REQ-022 SHALL transition EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop.
REQ-023 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, combinationally from state only (no dependence on out_ready).
REQ-024 SHALL drive out_valid = 1 in ONE and FULL; out_imm/out_tag always show the oldest entry.
REQ-025 SHALL present an item accepted in cycle N on the output in cycle N+1 at the earliest (latency 1).
REQ-026 SHALL hold out_imm/out_tag stable while out_valid & !out_ready.
REQ-027 SHALL ignore in_imm/in_mode/in_tag when no input transfer occurs.
REQ-028 SHALL sustain one item per cycle throughput when out_ready is held high.
REQ-029 SHALL preserve acceptance order; no item dropped or duplicated.

Reset
REQ-030 SHALL, on any rising edge with rst_n = 0, enter EMPTY, clear both entries, out_valid = 0, out_imm = 0, out_tag = 0.
REQ-031 SHALL drive in_ready = 0 while rst_n = 0, and 1 in the first cycle after release.
REQ-032 SHALL discard all buffered items when reset asserts mid-operation; no transfer completes in a reset cycle.

Structure
REQ-033 SHALL place mode constants (SIGN, ZERO, UPPER, BRANCH) and the buffer state encoding in shared package imm_ext_pkg.
REQ-034 SHALL implement the extension as a pure function in imm_ext_pkg, parametrised by IN_W/OUT_W.
REQ-035 SHALL implement the 2-entry store as one sub-module imm_buf2 (data+tag payload, valid/ready both sides).

Verification (IN_W=16, OUT_W=32)
REQ-036 SHALL cover: push 0x8000 SIGN, out_ready=1 -> next cycle out_imm=0xFFFF8000, out_valid=1.
REQ-037 SHALL cover: push 0x8000 ZERO, then 0x1234 UPPER -> 0x00008000, then 0x12340000, consecutive cycles.
REQ-038 SHALL cover: push 0xFFFF BRANCH tag 7 -> out_imm=0xFFFFFFFC, out_tag=7; 0x0001 BRANCH -> 0x00000004.
REQ-039 SHALL cover: out_ready=0, three back-to-back pushes -> in_ready low after second, third held; release out_ready -> three items in order.
REQ-040 SHALL cover: FULL with simultaneous pop and in_valid -> only pop occurs, state ONE, pending item accepted next cycle.
REQ-041 SHALL cover: rst_n low one cycle while FULL -> out_valid=0, out_imm=0, in_ready=1 next cycle, no stale item emitted.
